// File: rtl/serial_adder_seq_pkg.sv
// serial_adder_seq_pkg
//   Shared definitions for the bit-serial adder sequencer: FSM state
//   encodings, the default operand width, and small helpers used by the
//   sequencer and its full-adder cell.
package serial_adder_seq_pkg;

   // FSM state encodings (kept as plain constants for legacy compatibility)
   localparam logic [1:0] SA_IDLE = 2'd0;
   localparam logic [1:0] SA_RUN  = 2'd1;
   localparam logic [1:0] SA_DONE = 2'd2;

   localparam int unsigned SA_DEFAULT_WIDTH = 8;

   // Bit counter width: ceil(log2(width+1))
   function automatic int unsigned sa_cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

   // Majority of three: full-adder carry
   function automatic logic sa_maj(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/serial_adder_seq_fulladder.sv
// fulladder
//   Combinational ripple full adder, WIDTH bits wide. The serial sequencer
//   uses it with WIDTH=1 as its one-bit sum/carry cell.
//   Ports:
//     a, b  in  WIDTH : addends
//     cin   in  1     : carry in
//     s     out WIDTH : sum
//     cout  out 1     : carry out
module fulladder
   import serial_adder_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   logic [WIDTH:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < int'(WIDTH); i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = sa_maj(a[i], b[i], c[i]);
      end
   end

   assign cout = c[WIDTH];

endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq
//   Bit-serial adder sequencer. Accepts two operands one bit per clock, LSB
//   first, framed by a start pulse on bit 0. Owns the carry flop, feeds it
//   back into a one-bit fulladder and produces a registered serial sum, a
//   final carry and a one-cycle done pulse.
//   Configuration macro: SERIAL_ADDER_PAR_OUT_EN builds the parallel sum_q
//   shift register; when undefined sum_q is tied to 0.
//   Ports:
//     clk      in  1     : rising-edge clock
//     reset    in  1     : synchronous active-high reset
//     start    in  1     : cycle carries bit 0 of both operands
//     a, b     in  1     : serial operand bits
//     s        out 1     : registered serial sum bit
//     s_valid  out 1     : s holds a valid sum bit
//     c_out    out 1     : final carry of the last word (valid with done)
//     done     out 1     : one-cycle pulse after the last bit is summed
//     busy     out 1     : word in progress (RUN only)
//     sum_q    out WIDTH : parallel sum of the last completed word
module serial_adder_seq
   import serial_adder_seq_pkg::*;
#(
   parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             a,
   input  logic             b,
   output logic             s,
   output logic             s_valid,
   output logic             c_out,
   output logic             done,
   output logic             busy,
   output logic [WIDTH-1:0] sum_q
);

   localparam int unsigned CNT_W = sa_cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cy_q;
   logic             s_q;
   logic             s_valid_q;
   logic             c_out_q;

   logic first_bit;
   logic accept;
   logic last_bit;
   logic fa_cin;
   logic fa_s;
   logic fa_cout;

   // start only frames a word outside RUN; inside RUN it is ignored
   always_comb begin
      first_bit = start && (state_q != SA_RUN);
      accept    = first_bit || (state_q == SA_RUN);
      last_bit  = (first_bit && (WIDTH == 1)) ||
                  ((state_q == SA_RUN) && (cnt_q == CNT_LAST));
      // carry chain restarts at 0 on every new word, including back-to-back
      fa_cin    = first_bit ? 1'b0 : cy_q;
   end

   fulladder #(
      .WIDTH (1)
   ) u_fa (
      .a    (a),
      .b    (b),
      .cin  (fa_cin),
      .s    (fa_s),
      .cout (fa_cout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         SA_IDLE, SA_DONE: begin
            if (start) begin
               cnt_d   = CNT_ONE;
               state_d = (WIDTH == 1) ? SA_DONE : SA_RUN;
            end else begin
               state_d = SA_IDLE;
            end
         end
         SA_RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = SA_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = SA_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SA_IDLE;
         cnt_q     <= '0;
         cy_q      <= 1'b0;
         s_q       <= 1'b0;
         s_valid_q <= 1'b0;
         c_out_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s_valid_q <= accept;
         if (accept) begin
            s_q  <= fa_s;
            cy_q <= fa_cout;
         end
         // c_out tracks the final carry only, so it holds between words
         if (last_bit) begin
            c_out_q <= fa_cout;
         end
      end
   end

`ifdef SERIAL_ADDER_PAR_OUT_EN
   logic [WIDTH-1:0] sum_sr_q;
   logic [WIDTH:0]   sum_sr_ext;

   // New bit enters at the MSB; after WIDTH bits the LSB sits in bit 0
   always_comb begin
      sum_sr_ext = {fa_s, sum_sr_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_sr_q <= '0;
      end else if (accept) begin
         sum_sr_q <= sum_sr_ext[WIDTH:1];
      end
   end

   assign sum_q = sum_sr_q;
`else
   assign sum_q = '0;
`endif

   assign s       = s_q;
   assign s_valid = s_valid_q;
   assign c_out   = c_out_q;
   assign done    = (state_q == SA_DONE);
   assign busy    = (state_q == SA_RUN);

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq
//   Self-checking bench for serial_adder_seq at WIDTH=8: table of operand
//   pairs with hand-computed sums, plus hand-written sequences for a start
//   re-assert mid-word and a reset mid-word.
module tb_serial_adder_seq;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         a;
   logic         b;
   logic         s;
   logic         s_valid;
   logic         c_out;
   logic         done;
   logic         busy;
   logic [W-1:0] sum_q;

   int tests = 0;
   int fails = 0;

   serial_adder_seq #(
      .WIDTH (W)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .s       (s),
      .s_valid (s_valid),
      .c_out   (c_out),
      .done    (done),
      .busy    (busy),
      .sum_q   (sum_q)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [W-1:0] sum;
      logic         cout;
      bit           b2b;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] exp_par(input logic [W-1:0] v);
`ifdef SERIAL_ADDER_PAR_OUT_EN
      return v;
`else
      return '0;
`endif
   endfunction

   // Presents one word LSB-first; ends #1 after the edge that enters DONE
   task automatic run_word(input logic [W-1:0] wa, input logic [W-1:0] wb,
                           input logic [W-1:0] exp_sum, input logic exp_c,
                           input int restart_bit);
      for (int i = 0; i < int'(W); i++) begin
         @(negedge clk);
         start = (i == 0) || (i == restart_bit);
         a     = wa[i];
         b     = wb[i];
         @(posedge clk);
         #1;
         check("s_bit", {31'd0, s}, {31'd0, exp_sum[i]});
         check("s_valid", {31'd0, s_valid}, 32'd1);
         if (i < int'(W) - 1) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_early", {31'd0, done}, 32'd0);
         end
      end
      check("done_pulse", {31'd0, done}, 32'd1);
      check("busy_done", {31'd0, busy}, 32'd0);
      check("c_out", {31'd0, c_out}, {31'd0, exp_c});
      check("sum_q", {24'd0, sum_q}, {24'd0, exp_par(exp_sum)});
   endtask

   task automatic idle_cycle(input logic exp_c);
      @(negedge clk);
      start = 1'b0;
      a     = 1'b0;
      b     = 1'b0;
      @(posedge clk);
      #1;
      check("done_idle", {31'd0, done}, 32'd0);
      check("s_valid_idle", {31'd0, s_valid}, 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
      check("c_out_hold", {31'd0, c_out}, {31'd0, exp_c});
   endtask

   initial begin
      logic       prev_c;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vecs[0] = '{va: 8'h5A, vb: 8'h33, sum: 8'h8D, cout: 1'b0, b2b: 1'b0};
      vecs[1] = '{va: 8'hFF, vb: 8'h01, sum: 8'h00, cout: 1'b1, b2b: 1'b0};
      vecs[2] = '{va: 8'h01, vb: 8'h01, sum: 8'h02, cout: 1'b0, b2b: 1'b1};
      vecs[3] = '{va: 8'hAA, vb: 8'h55, sum: 8'hFF, cout: 1'b0, b2b: 1'b0};
      vecs[4] = '{va: 8'h80, vb: 8'h80, sum: 8'h00, cout: 1'b1, b2b: 1'b0};
      vecs[5] = '{va: 8'hC3, vb: 8'h7E, sum: 8'h41, cout: 1'b1, b2b: 1'b0};

      reset = 1'b1;
      start = 1'b1;
      a     = 1'b1;
      b     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_s", {31'd0, s}, 32'd0);
      check("rst_s_valid", {31'd0, s_valid}, 32'd0);
      check("rst_c_out", {31'd0, c_out}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sum_q", {24'd0, sum_q}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      a     = 1'b0;
      b     = 1'b0;

      prev_c = 1'b0;
      for (int v = 0; v < 6; v++) begin
         if (!vecs[v].b2b) idle_cycle(prev_c);
         run_word(vecs[v].va, vecs[v].vb, vecs[v].sum, vecs[v].cout, -1);
         prev_c = vecs[v].cout;
      end
      idle_cycle(prev_c);

      // start re-asserted at bit 3 must not restart the word
      run_word(8'h0F, 8'h0F, 8'h1E, 1'b0, 3);
      idle_cycle(1'b0);

      // leave c_out=1 so the reset clear is observable
      run_word(8'hFF, 8'h01, 8'h00, 1'b1, -1);
      idle_cycle(1'b1);

      // reset at bit 4 of 0xFF+0xFF
      ra = 8'hFF;
      rb = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start = (i == 0);
         a     = ra[i];
         b     = rb[i];
         @(posedge clk);
      end
      #1;
      check("pre_rst_s", {31'd0, s}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_s", {31'd0, s}, 32'd0);
      check("mid_rst_s_valid", {31'd0, s_valid}, 32'd0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_c_out", {31'd0, c_out}, 32'd0);
      check("mid_rst_sum_q", {24'd0, sum_q}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      a     = 1'b0;
      b     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("no_done_after_rst", {31'd0, done}, 32'd0);
      end
      run_word(8'h10, 8'h20, 8'h30, 1'b0, -1);
      idle_cycle(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
